// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-cycle shift sequencer.
package shift_pkg;

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shift_step.sv
// Combinational bounded shifter: moves acc by step bits, filling vacated bits with fill.
module shift_step
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned AMT_W = 5
) (
   input  logic [WIDTH-1:0] acc,
   input  logic             dir,
   input  logic             fill,
   input  logic [AMT_W-1:0] step,
   output logic [WIDTH-1:0] shifted
);

   localparam logic [WIDTH-1:0] Ones = '1;

   always_comb begin
      shifted = acc;
      if (dir == DIR_LEFT) begin
         shifted = (acc << step) | ({WIDTH{fill}} & ~(Ones << step));
      end else begin
         shifted = (acc >> step) | ({WIDTH{fill}} & ~(Ones >> step));
      end
   end

endmodule

// File: rtl/shift_sequencer.sv
// Valid/ready shift controller that applies a variable shift as a series of
// steps of at most MAX_STEP bits, using one small step shifter.
module shift_sequencer
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned MAX_STEP = 8,
   localparam int unsigned AMT_W   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_dir,
   input  logic [AMT_W-1:0] req_amt,
   input  logic             req_fill,
   input  logic [WIDTH-1:0] req_data,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             busy
);

   localparam logic [AMT_W-1:0] MaxStep = AMT_W'(MAX_STEP);

   state_e           state;
   logic [WIDTH-1:0] acc;
   logic [AMT_W-1:0] rem;
   logic [AMT_W-1:0] step;
   logic             dir;
   logic             fill;
   logic [WIDTH-1:0] shifted;

   // step never exceeds rem, so rem cannot underflow
   assign step = (rem > MaxStep) ? MaxStep : rem;

   shift_step #(
      .WIDTH (WIDTH),
      .AMT_W (AMT_W)
   ) u_shift_step (
      .acc     (acc),
      .dir     (dir),
      .fill    (fill),
      .step    (step),
      .shifted (shifted)
   );

   always_ff @(posedge clk) begin
      if (clr) begin
         state     <= StIdle;
         acc       <= '0;
         rem       <= '0;
         dir       <= 1'b0;
         fill      <= 1'b0;
         req_ready <= 1'b1;
         res_valid <= 1'b0;
         res_data  <= '0;
         busy      <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (req_valid) begin
                  dir       <= req_dir;
                  fill      <= req_fill;
                  acc       <= req_data;
                  rem       <= req_amt;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
                  if (req_amt != '0) begin
                     state <= StShift;
                  end else begin
                     state     <= StDone;
                     res_valid <= 1'b1;
                     res_data  <= req_data;
                  end
               end
            end
            StShift: begin
               acc <= shifted;
               rem <= rem - step;
               if (rem == step) begin
                  state     <= StDone;
                  res_valid <= 1'b1;
                  res_data  <= shifted;
               end
            end
            StDone: begin
               if (res_ready) begin
                  state     <= StIdle;
                  res_valid <= 1'b0;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= StIdle;
               req_ready <= 1'b1;
               res_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed and randomized checks of shift_sequencer against a bitwise reference shift.
module tb_shift_sequencer;

   localparam int WIDTH    = 32;
   localparam int MAX_STEP = 8;
   localparam int AMT_W    = 5;

   logic             clk = 1'b0;
   logic             clr = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic             req_dir = 1'b0;
   logic [AMT_W-1:0] req_amt = '0;
   logic             req_fill = 1'b0;
   logic [WIDTH-1:0] req_data = '0;
   logic             res_valid;
   logic             res_ready = 1'b0;
   logic [WIDTH-1:0] res_data;
   logic             busy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   shift_sequencer #(
      .WIDTH    (WIDTH),
      .MAX_STEP (MAX_STEP)
   ) dut (
      .clk       (clk),
      .clr       (clr),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_dir   (req_dir),
      .req_amt   (req_amt),
      .req_fill  (req_fill),
      .req_data  (req_data),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .busy      (busy)
   );

   // Reference: every result bit either comes from the source bit amt away or is fill.
   function automatic logic [WIDTH-1:0] ref_shift(input logic d, input int amt,
                                                  input logic f, input logic [WIDTH-1:0] x);
      logic [WIDTH-1:0] r;
      for (int i = 0; i < WIDTH; i++) begin
         int src;
         src = d ? i - amt : i + amt;
         r[i] = (src >= 0 && src < WIDTH) ? x[src] : f;
      end
      return r;
   endfunction

   function automatic int ref_latency(input int amt);
      return (amt + MAX_STEP - 1) / MAX_STEP + 1;
   endfunction

   task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                        input logic [WIDTH-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offers one job in IDLE, waits (bounded) for res_valid; leaves res_ready low.
   task automatic run_job(input string tag, input logic d, input int amt, input logic f,
                          input logic [WIDTH-1:0] x);
      int lat;
      check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_dir   = d;
      req_amt   = AMT_W'(amt);
      req_fill  = f;
      req_data  = x;
      res_ready = 1'b0;
      tick();
      req_valid = 1'b0;
      req_data  = $urandom;
      req_amt   = AMT_W'($urandom);
      lat = 1;
      while (!res_valid && lat < 64) begin
         tick();
         lat++;
      end
      check({tag, "_res_valid"}, 32'(res_valid), 32'd1);
      check({tag, "_latency"}, 32'(lat), 32'(ref_latency(amt)));
      check({tag, "_res_data"}, res_data, ref_shift(d, amt, f, x));
      check({tag, "_busy"}, 32'(busy), 32'd1);
   endtask

   task automatic complete(input string tag);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check({tag, "_done_valid"}, 32'(res_valid), 32'd0);
      check({tag, "_done_ready"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      logic [WIDTH-1:0] held;
      logic [WIDTH-1:0] exp_q[$];
      int last_accept;
      int accepts;
      int cyc;

      // Reset
      clr = 1'b1;
      req_valid = 1'b1;
      tick();
      tick();
      clr = 1'b0;
      req_valid = 1'b0;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_data", res_data, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);

      // Directed jobs
      run_job("left20", 1'b1, 20, 1'b0, 32'h0000_00FF);
      check("left20_const", res_data, 32'h0FF0_0000);
      complete("left20");
      run_job("right0", 1'b0, 0, 1'b0, 32'hDEAD_BEEF);
      check("right0_const", res_data, 32'hDEAD_BEEF);
      complete("right0");
      run_job("right31", 1'b0, 31, 1'b1, 32'h0000_0000);
      check("right31_const", res_data, 32'hFFFF_FFFE);

      // Backpressure in DONE while requests are offered
      held = res_data;
      for (int i = 0; i < 5; i++) begin
         req_valid = i[0];
         req_data  = $urandom;
         req_amt   = AMT_W'($urandom);
         tick();
         check("hold_valid", 32'(res_valid), 32'd1);
         check("hold_data", res_data, held);
         check("hold_req_ready", 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      complete("hold");
      repeat (3) tick();
      check("hold_no_extra_valid", 32'(res_valid), 32'd0);
      check("hold_no_extra_busy", 32'(busy), 32'd0);

      // Reset in the middle of SHIFT
      req_valid = 1'b1;
      req_dir   = 1'b1;
      req_amt   = AMT_W'(30);
      req_data  = 32'hFFFF_FFFF;
      tick();
      req_valid = 1'b0;
      tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr_req_ready", 32'(req_ready), 32'd1);
      check("clr_res_valid", 32'(res_valid), 32'd0);
      check("clr_busy", 32'(busy), 32'd0);
      repeat (5) begin
         tick();
         check("clr_no_pulse", 32'(res_valid), 32'd0);
      end
      run_job("after_clr", 1'b1, 4, 1'b0, 32'h0000_0001);
      check("after_clr_const", res_data, 32'h0000_0010);
      complete("after_clr");

      // Randomized jobs
      for (int j = 0; j < 24; j++) begin
         run_job("rand", 1'($urandom), int'($urandom_range(0, WIDTH - 1)), 1'($urandom),
                 $urandom);
         complete("rand");
      end

      // Streaming: req_valid and res_ready held high, amt=9
      res_ready   = 1'b1;
      req_valid   = 1'b1;
      req_amt     = AMT_W'(9);
      req_dir     = 1'($urandom);
      req_fill    = 1'($urandom);
      req_data    = $urandom;
      last_accept = -1;
      accepts     = 0;
      for (cyc = 0; cyc < 40; cyc++) begin
         logic was_ready;
         logic was_valid;
         was_ready = req_ready;
         was_valid = res_valid;
         if (was_ready) exp_q.push_back(ref_shift(req_dir, 9, req_fill, req_data));
         if (was_valid) begin
            if (exp_q.size() == 0) begin
               check("stream_unexpected", 32'd1, 32'd0);
            end else begin
               check("stream_data", res_data, exp_q.pop_front());
            end
         end
         tick();
         if (was_ready) begin
            if (last_accept >= 0) check("stream_interval", 32'(cyc - last_accept), 32'd4);
            last_accept = cyc;
            accepts++;
            req_dir  = 1'($urandom);
            req_fill = 1'($urandom);
            req_data = $urandom;
         end
      end
      req_valid = 1'b0;
      check("stream_accepts", 32'(accepts), 32'd10);
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 20) begin
         if (res_valid) check("stream_drain", res_data, exp_q.pop_front());
         tick();
         cyc++;
      end
      check("stream_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
